// File: rtl/adder_arb_pkg.sv
// Shared constants and state type for the two-requester adder arbiter.
// Optional multi-word carry chaining is enabled with the ADDER_ARB_CHAIN_EN macro.
package adder_arb_pkg;

    localparam int ADDER_W = 32;
    localparam int NUM_REQ = 2;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/adder_arbiter_ks_adder.sv
// 32-bit Kogge-Stone parallel-prefix adder with carry-in and carry-out.
// The carry-in is folded into bit 0's generate so the prefix tree needs no extra level.
module KoggeStone32Bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] prop;
    logic [31:0] g_lvl [6];
    logic [31:0] p_lvl [5];
    logic [31:0] carry;

    always_comb begin
        prop = a ^ b;
        g_lvl[0] = a & b;
        g_lvl[0][0] = (a[0] & b[0]) | (prop[0] & cin);
        p_lvl[0] = prop;
        for (int k = 1; k < 5; k++) begin
            for (int i = 0; i < 32; i++) begin
                if (i >= (1 << (k - 1))) begin
                    g_lvl[k][i] = g_lvl[k-1][i] | (p_lvl[k-1][i] & g_lvl[k-1][i - (1 << (k - 1))]);
                    p_lvl[k][i] = p_lvl[k-1][i] & p_lvl[k-1][i - (1 << (k - 1))];
                end else begin
                    g_lvl[k][i] = g_lvl[k-1][i];
                    p_lvl[k][i] = p_lvl[k-1][i];
                end
            end
        end
        // Last level only needs generate terms: span 16 completes every prefix.
        for (int i = 0; i < 32; i++) begin
            if (i >= 16) begin
                g_lvl[5][i] = g_lvl[4][i] | (p_lvl[4][i] & g_lvl[4][i - 16]);
            end else begin
                g_lvl[5][i] = g_lvl[4][i];
            end
        end
        carry = {g_lvl[5][30:0], cin};
        sum   = prop ^ carry;
        cout  = g_lvl[5][31];
    end

endmodule

// File: rtl/adder_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with an internal priority pointer and an owner lock.
module rr_arb2
    import adder_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               lock,
    input  logic               lock_id,
    input  logic               update,
    input  logic               served_id,
    output logic [NUM_REQ-1:0] grant
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        ptr_d = update ? ~served_id : ptr_q;
        grant = '0;
        if (lock) begin
            grant[lock_id] = req[lock_id];
        end else if (&req) begin
            grant[ptr_q] = 1'b1;
        end else begin
            grant = req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Two requesters time-share one 32-bit adder through a round-robin arbiter and a
// one-deep result register. ADDER_ARB_CHAIN_EN adds multi-word carry chaining.
module adder_arbiter
    import adder_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [ADDER_W-1:0] req_a0,
    input  logic [ADDER_W-1:0] req_b0,
    input  logic [ADDER_W-1:0] req_a1,
    input  logic [ADDER_W-1:0] req_b1,
    input  logic [NUM_REQ-1:0] req_cin,
    input  logic [NUM_REQ-1:0] req_last,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_id,
    output logic [ADDER_W-1:0] res_sum,
    output logic               res_cout,
    output logic               res_last
);

    arb_state_e         state_q, state_d;
    logic               res_valid_q, res_valid_d;
    logic               res_id_q, res_id_d;
    logic [ADDER_W-1:0] res_sum_q, res_sum_d;
    logic               res_cout_q, res_cout_d;
    logic               res_last_q, res_last_d;

    logic [NUM_REQ-1:0] grant;
    logic               can_load;
    logic               xfer;
    logic               xfer_id;
    logic               op_last;
    logic               locked;
    logic [ADDER_W-1:0] op_a, op_b;
    logic               add_cin;
    logic [ADDER_W-1:0] add_sum;
    logic               add_cout;

`ifdef ADDER_ARB_CHAIN_EN
    assign op_last = req_last[xfer_id];
`else
    logic unused_req_last;
    assign unused_req_last = ^req_last;
    assign op_last = 1'b1;
`endif

    assign locked    = (state_q == LOCKED);
    assign can_load  = ~res_valid_q | res_ready;
    assign req_ready = rst ? '0 : (grant & {NUM_REQ{can_load}});
    assign xfer      = |req_ready;
    assign xfer_id   = req_ready[1];
    assign op_a      = xfer_id ? req_a1 : req_a0;
    assign op_b      = xfer_id ? req_b1 : req_b0;
    // A locked chain continues from the owner's previous carry-out.
    assign add_cin   = locked ? res_cout_q : req_cin[xfer_id];

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .lock      (locked),
        .lock_id   (res_id_q),
        .update    (xfer & op_last),
        .served_id (xfer_id),
        .grant     (grant)
    );

    KoggeStone32Bit u_adder (
        .a    (op_a),
        .b    (op_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d     = state_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_sum_d   = res_sum_q;
        res_cout_d  = res_cout_q;
        res_last_d  = res_last_q;
        if (xfer) begin
            res_valid_d = 1'b1;
            res_id_d    = xfer_id;
            res_sum_d   = add_sum;
            res_cout_d  = add_cout;
            res_last_d  = op_last;
            state_d     = op_last ? ARB : LOCKED;
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
            res_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_sum_q   <= res_sum_d;
            res_cout_q  <= res_cout_d;
            res_last_q  <= res_last_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;
    assign res_last  = res_last_q;

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have no parameters; datapath width is fixed at 32 bits (ADDER_W in adder_arb_pkg).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  2  per-requester operation request (bit i = requester i).
REQ-005 req_ready  output  2  per-requester accept; transfer when req_valid[i] & req_ready[i].
REQ-006 req_a0, req_b0 / req_a1, req_b1  input  32 each  operands of requester 0 / 1.
REQ-007 req_cin  input  2  per-requester carry-in.
REQ-008 req_last  input  2  1 = final word of operation; 0 = more words follow (chain mode only).
REQ-009 res_valid  output  1  result register holds a valid result.
REQ-010 res_ready  input  1  consumer accepts result when res_valid & res_ready.
REQ-011 res_id  output  1  requester that owns the result.
REQ-012 res_sum  output  32  sum; res_cout  output  1  carry-out.
REQ-013 res_last  output  1  copy of the accepted req_last.

Function
REQ-014 SHALL time-share one 32-bit adder; at most one transfer per cycle; req_ready one-hot or zero.
REQ-015 SHALL grant round-robin: on conflict, the requester not served last wins; after reset requester 0 has priority.
REQ-016 req_ready[i] SHALL be grant[i] & (~res_valid | res_ready); grant is computed combinationally from req_valid, pointer and state.
REQ-017 On transfer, res_sum/res_cout/res_id/res_last SHALL be registered and res_valid set next cycle (latency 1 cycle).
REQ-018 Simultaneous result drain and new transfer SHALL keep res_valid high with new data, no bubble (full throughput).
REQ-019 Drain without transfer SHALL clear res_valid; res_valid & ~res_ready SHALL hold all res_* stable.
REQ-020 FSM states: ARB (free arbitration) and LOCKED (owner fixed); LOCKED exists only with ADDER_ARB_CHAIN_EN.
REQ-021 ARB->LOCKED on transfer with req_last=0; LOCKED->ARB on owner transfer with req_last=1; otherwise state holds.
REQ-022 In LOCKED, only the owner SHALL be granted; other requester's req_ready stays 0 regardless of its req_valid.
REQ-023 In LOCKED, adder carry-in SHALL be the stored res_cout of the owner's previous word; req_cin ignored.
REQ-024 Round-robin pointer SHALL update only on transfer with req_last=1 (or every transfer when chain disabled).
REQ-025 Carry-out SHALL be bit 32 of a + b + cin; sum wraps modulo 2^32.

Reset
REQ-026 rst SHALL set res_valid=0, res_sum=0, res_cout=0, res_id=0, res_last=0, state=ARB, pointer to requester-0 priority.
REQ-027 rst mid-chain SHALL abandon the chain; no stale carry used afterward; req_ready=0 during rst cycle.

Configuration
REQ-028 Macro ADDER_ARB_CHAIN_EN defined: multi-word carry chaining and LOCKED state per REQ-020..023.
REQ-029 Macro undefined: req_last ignored (treated as 1), FSM fixed in ARB, carry-in always req_cin, res_last always 1.

Structure
REQ-030 adder_arb_pkg SHALL hold ADDER_W=32, NUM_REQ=2, state enum {ARB, LOCKED}.
REQ-031 Adder SHALL be a single instance of KoggeStone32Bit; arbitration logic SHALL be sub-module rr_arb2 (2-way round-robin, pointer inside).

Verification
REQ-032 Single request: req0 a=0xFFFFFFFF b=1 cin=0 -> next cycle res_valid=1, res_sum=0, res_cout=1, res_id=0.
REQ-033 Both valid continuously, res_ready=1 -> grants alternate 0,1,0,1; one result per cycle, res_id alternating.
REQ-034 Backpressure: res_ready=0 for 3 cycles -> req_ready=0, res_* stable; res_ready=1 -> drain and accept same cycle.
REQ-035 Chain (macro on): req1 64-bit add 0x00000001_FFFFFFFF + 0x00000000_00000001 as two words, req0 valid throughout -> sums 0x00000000 (cout 1) then 0x00000002 (cout 0), req0 blocked until last word.
REQ-036 rst asserted while LOCKED -> next cycle state ARB, res_valid=0, req0 granted on next request with cin from req_cin.
